// File: rtl/inst_rom_resp.sv
// -----------------------------------------------------------------------------
// inst_rom_resp
//
// Instruction-memory responder for the fetch stage. Accepts the program
// counter's fetch request (ce/addr), waits WAIT_CYCLES clock cycles, then
// returns the 32-bit instruction word for one cycle on inst/inst_valid. While
// an access is in flight it raises stallreq so the pipeline controller freezes
// the PC. A separate write port preloads program contents at any time.
//
// Parameters
//   DEPTH_LOG2  : memory holds 2**DEPTH_LOG2 32-bit words
//   WAIT_CYCLES : wait states between acceptance and response, 0..15
//   INIT_FILE   : optional hex image name ("" = no image)
//
// Ports
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous, active-high reset
//   ce         in   1   fetch request valid (chip enable from the PC register)
//   addr       in  32   byte address of the requested instruction
//   inst       out 32   instruction word, meaningful while inst_valid=1
//   inst_valid out  1   one-cycle response strobe
//   misaligned out  1   answered address had addr[1:0] != 0 (inst forced to 0)
//   stallreq   out  1   combinational stall request to the controller
//   load_we    in   1   program-load write enable
//   load_addr  in  DEPTH_LOG2  word index of the load write
//   load_data  in  32   word to write
// -----------------------------------------------------------------------------
module inst_rom_resp #(
  parameter int    DEPTH_LOG2  = 10,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [31:0]           addr,
  output logic [31:0]           inst,
  output logic                  inst_valid,
  output logic                  misaligned,
  output logic                  stallreq,
  input  logic                  load_we,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [31:0]           load_data
);

  localparam int         DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam bit         HAS_WAIT  = (WAIT_CYCLES != 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [31:0] mem [DEPTH];

  // NOTE: the array has no reset; its contents survive rst and only change
  // through the load port, which is what a program image needs.
  always_ff @(posedge clk) begin
    if (load_we) mem[load_addr] <= load_data;
  end

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [DEPTH_LOG2-1:0] addr_idx;
  logic                  addr_mis;
  logic                  unused_addr_hi;

  // Upper address bits are dropped on purpose: addresses wrap modulo depth.
  assign addr_idx       = addr[DEPTH_LOG2+1:2];
  assign addr_mis       = |addr[1:0];
  assign unused_addr_hi = ^addr[31:DEPTH_LOG2+2];

  // ---------------------------------------------------------------------------
  // FSM state and access context
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic                  mis_q, mis_d;
  logic [31:0]           inst_q, inst_d;
  logic                  inst_valid_q, inst_valid_d;
  logic                  misaligned_q, misaligned_d;

  // NOTE: every sequential element is written with <= so all flops sample
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      mis_q        <= 1'b0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      mis_q        <= mis_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Next-state logic. IDLE and RESP share the accept rule, so a new request
  // can be taken in the same cycle the previous response is presented.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no
    // latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    mis_d   = mis_q;
    unique case (state_q)
      S_IDLE, S_RESP: begin
        if (ce) begin
          idx_d   = addr_idx;
          mis_d   = addr_mis;
          cnt_d   = WAIT_INIT;
          state_d = HAS_WAIT ? S_WAIT : S_RESP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Dropping ce mid-wait abandons the access without a response.
        if (!ce) begin
          state_d = S_IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Response datapath. The array is read on the edge that enters RESP; the
  // read sees the contents from before that edge, so a same-edge load write
  // to the same word is observed only by a later fetch. idx_d/mis_d already
  // select the fresh address when the request is answered with no wait.
  always_comb begin
    inst_d       = inst_q;
    misaligned_d = misaligned_q;
    inst_valid_d = 1'b0;
    if (state_d == S_RESP) begin
      inst_valid_d = 1'b1;
      misaligned_d = mis_d;
      inst_d       = mis_d ? 32'h0000_0000 : mem[idx_d];
    end
  end

  // Stall output. The accept cycle plus all but the last WAIT cycle stall,
  // which lets the PC advance on the edge that enters RESP.
  always_comb begin
    stallreq = 1'b0;
    unique case (state_q)
      S_IDLE, S_RESP: stallreq = ce && HAS_WAIT;
      S_WAIT:         stallreq = ce && (cnt_q > 4'd1);
      default:        stallreq = 1'b0;
    endcase
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_inst_rom_resp.sv
// -----------------------------------------------------------------------------
// tb_inst_rom_resp
//
// Three responders with WAIT_CYCLES = 2, 0 and 3 share clock, reset and the
// load port; each has its own fetch request inputs. Directed scenarios cover
// the documented cases; a randomized run compares all three against a
// transaction-level model (acceptance time + wait states -> response).
// -----------------------------------------------------------------------------
module tb_inst_rom_resp;

  localparam int N   = 3;
  localparam int DL2 = 10;
  localparam int W0  = 2;
  localparam int W1  = 0;
  localparam int W2  = 3;

  int wc [N] = '{W0, W1, W2};

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        ce;
  logic [N-1:0][31:0]  addr;
  logic [N-1:0][31:0]  inst;
  logic [N-1:0]        inst_valid;
  logic [N-1:0]        misaligned;
  logic [N-1:0]        stallreq;
  logic                load_we;
  logic [DL2-1:0]      load_addr;
  logic [31:0]         load_data;

  logic [31:0] mem_model [1 << DL2];
  int checks = 0;
  int errors = 0;

  // Transaction-level model state, one entry per responder.
  bit          m_busy [N];
  int          m_age  [N];
  int          m_idx  [N];
  bit          m_mis  [N];
  bit          m_vld  [N];
  logic [31:0] m_inst [N];
  bit          m_misq [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    inst_rom_resp #(
      .DEPTH_LOG2 (DL2),
      .WAIT_CYCLES(g == 0 ? W0 : (g == 1 ? W1 : W2)),
      .INIT_FILE  ("")
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce[g]),
      .addr      (addr[g]),
      .inst      (inst[g]),
      .inst_valid(inst_valid[g]),
      .misaligned(misaligned[g]),
      .stallreq  (stallreq[g]),
      .load_we   (load_we),
      .load_addr (load_addr),
      .load_data (load_data)
    );
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic load_word(input int idx, input logic [31:0] data);
    load_we   = 1'b1;
    load_addr = DL2'(idx);
    load_data = data;
    tick();
    load_we   = 1'b0;
    mem_model[idx] = data;
  endtask

  // Presents one request and waits (bounded) for its response. Returns in the
  // response cycle with ce still high; lat = -1 means no response arrived.
  task automatic fetch_one(input int g, input logic [31:0] a,
                           output logic [31:0] got_inst, output logic got_mis,
                           output int lat);
    ce[g]   = 1'b1;
    addr[g] = a;
    got_inst = 'x;
    got_mis  = 1'bx;
    settle();
    tick();
    lat = 1;
    while (lat <= 40) begin
      settle();
      if (inst_valid[g] === 1'b1) begin
        got_inst = inst[g];
        got_mis  = misaligned[g];
        return;
      end
      tick();
      lat++;
    end
    lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ce  = '0;
    addr = '0;
    tick();
    load_word(0, 32'h3C01_0001);
    for (int c = 0; c < 2; c++) begin
      settle();
      for (int g = 0; g < N; g++) begin
        checks++; if (inst[g] !== 32'h0) begin errors++; $display("FAIL reset_inst[%0d]: got %h want 0", g, inst[g]); end
        checks++; if (inst_valid[g] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b want 0", g, inst_valid[g]); end
        checks++; if (misaligned[g] !== 1'b0) begin errors++; $display("FAIL reset_mis[%0d]: got %b want 0", g, misaligned[g]); end
        checks++; if (stallreq[g] !== 1'b0) begin errors++; $display("FAIL reset_stall[%0d]: got %b want 0", g, stallreq[g]); end
      end
      tick();
    end
  endtask

  task automatic test_first_fetch();
    logic exp_stall [3] = '{1'b1, 1'b1, 1'b0};
    rst     = 1'b0;
    ce[0]   = 1'b1;
    addr[0] = 32'h0;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (stallreq[0] !== exp_stall[c]) begin errors++; $display("FAIL first_stall_c%0d: got %b want %b", c, stallreq[0], exp_stall[c]); end
      checks++; if (inst_valid[0] !== 1'b0) begin errors++; $display("FAIL first_early_valid_c%0d: got %b want 0", c, inst_valid[0]); end
      tick();
    end
    settle();
    checks++; if (inst_valid[0] !== 1'b1) begin errors++; $display("FAIL first_valid: got %b want 1", inst_valid[0]); end
    checks++; if (inst[0] !== 32'h3C01_0001) begin errors++; $display("FAIL first_inst: got %h want 3c010001", inst[0]); end
    checks++; if (misaligned[0] !== 1'b0) begin errors++; $display("FAIL first_mis: got %b want 0", misaligned[0]); end
    ce[0] = 1'b0;
    tick();
    settle();
    checks++; if (inst_valid[0] !== 1'b0) begin errors++; $display("FAIL first_pulse_width: got %b want 0", inst_valid[0]); end
    checks++; if (inst[0] !== 32'h3C01_0001) begin errors++; $display("FAIL first_hold: got %h want 3c010001", inst[0]); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] want;
    for (int k = 0; k < 4; k++) load_word(k, 32'(8'h11 * (k + 1)));
    for (int k = 0; k <= 4; k++) begin
      ce[1]   = (k < 4);
      addr[1] = 32'(4 * k);
      settle();
      checks++; if (stallreq[1] !== 1'b0) begin errors++; $display("FAIL b2b_stall_k%0d: got %b want 0", k, stallreq[1]); end
      if (k > 0) begin
        want = 32'(8'h11 * k);
        checks++; if (inst_valid[1] !== 1'b1) begin errors++; $display("FAIL b2b_valid_k%0d: got %b want 1", k, inst_valid[1]); end
        checks++; if (inst[1] !== want) begin errors++; $display("FAIL b2b_inst_k%0d: got %h want %h", k, inst[1], want); end
      end
      tick();
    end
    settle();
    checks++; if (inst_valid[1] !== 1'b0) begin errors++; $display("FAIL b2b_tail_valid: got %b want 0", inst_valid[1]); end
  endtask

  task automatic test_pc_stream();
    logic [31:0] pc = 32'h100;
    int got = 0;
    int last = 0;
    int cyc = 0;
    int advances = 0;
    for (int k = 0; k < 8; k++) load_word(64 + k, $urandom());
    ce[0] = 1'b1;
    while (got < 8 && cyc < 100) begin
      addr[0] = pc;
      settle();
      if (inst_valid[0] === 1'b1) begin
        checks++; if (inst[0] !== mem_model[64 + got]) begin errors++; $display("FAIL pc_inst_%0d: got %h want %h", got, inst[0], mem_model[64 + got]); end
        if (got > 0) begin
          checks++; if (cyc - last != 3) begin errors++; $display("FAIL pc_spacing_%0d: got %0d want 3", got, cyc - last); end
        end
        last = cyc;
        got++;
        if (got == 8) begin
          ce[0] = 1'b0;
          settle();
        end
      end
      if (ce[0] && stallreq[0] === 1'b0) begin
        pc = pc + 32'd4;
        advances++;
      end
      tick();
      cyc++;
    end
    checks++; if (got != 8) begin errors++; $display("FAIL pc_count: got %0d want 8", got); end
    checks++; if (advances != 8) begin errors++; $display("FAIL pc_advances: got %0d want 8", advances); end
  endtask

  task automatic test_misaligned();
    logic [31:0] gi;
    logic        gm;
    int          lat;
    load_word(1, 32'hA5A5_5A5A);
    load_word(2, 32'h0000_BEEF);
    fetch_one(0, 32'h6, gi, gm, lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL mis_lat: got %0d want 3", lat); end
    checks++; if (gi !== 32'h0) begin errors++; $display("FAIL mis_inst: got %h want 0", gi); end
    checks++; if (gm !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b want 1", gm); end
    fetch_one(0, 32'h8, gi, gm, lat);
    checks++; if (lat != 3) begin errors++; $display("FAIL mis_next_lat: got %0d want 3", lat); end
    checks++; if (gi !== 32'h0000_BEEF) begin errors++; $display("FAIL mis_next_inst: got %h want 0000beef", gi); end
    checks++; if (gm !== 1'b0) begin errors++; $display("FAIL mis_next_flag: got %b want 0", gm); end
    ce[0] = 1'b0;
    tick();
    fetch_one(1, 32'h5, gi, gm, lat);
    checks++; if (gi !== 32'h0 || gm !== 1'b1 || lat != 1) begin errors++; $display("FAIL mis_w0: got inst %h mis %b lat %0d want 0/1/1", gi, gm, lat); end
    fetch_one(1, 32'h4, gi, gm, lat);
    checks++; if (gi !== 32'hA5A5_5A5A || gm !== 1'b0 || lat != 1) begin errors++; $display("FAIL mis_w0_next: got inst %h mis %b lat %0d want a5a55a5a/0/1", gi, gm, lat); end
    ce[1] = 1'b0;
    tick();
  endtask

  task automatic test_abort_ce();
    logic [31:0] gi;
    logic        gm;
    int          lat;
    load_word(3, 32'h3333_0003);
    load_word(4, 32'h4444_0004);
    // Short wait: drop ce in the first WAIT cycle.
    ce[0] = 1'b1; addr[0] = 32'hC;
    settle(); tick();
    ce[0] = 1'b0;
    settle();
    checks++; if (stallreq[0] !== 1'b0) begin errors++; $display("FAIL abort_stall: got %b want 0", stallreq[0]); end
    tick();
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++; if (inst_valid[0] !== 1'b0) begin errors++; $display("FAIL abort_valid_c%0d: got %b want 0", c, inst_valid[0]); end
      tick();
    end
    fetch_one(0, 32'h10, gi, gm, lat);
    checks++; if (lat != 3 || gi !== 32'h4444_0004) begin errors++; $display("FAIL abort_next: got inst %h lat %0d want 44440004/3", gi, lat); end
    ce[0] = 1'b0;
    tick();
    // Long wait: drop ce in the last WAIT cycle (counter at 1).
    ce[2] = 1'b1; addr[2] = 32'hC;
    settle(); tick();
    settle(); tick();
    settle();
    checks++; if (stallreq[2] !== 1'b1) begin errors++; $display("FAIL abort3_stall_mid: got %b want 1", stallreq[2]); end
    tick();
    settle();
    checks++; if (stallreq[2] !== 1'b0) begin errors++; $display("FAIL abort3_stall_last: got %b want 0", stallreq[2]); end
    ce[2] = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++; if (inst_valid[2] !== 1'b0) begin errors++; $display("FAIL abort3_valid_c%0d: got %b want 0", c, inst_valid[2]); end
      tick();
    end
    fetch_one(2, 32'h10, gi, gm, lat);
    checks++; if (lat != 4 || gi !== 32'h4444_0004) begin errors++; $display("FAIL abort3_next: got inst %h lat %0d want 44440004/4", gi, lat); end
    ce[2] = 1'b0;
    tick();
  endtask

  task automatic test_abort_rst();
    logic [31:0] gi;
    logic        gm;
    int          lat;
    load_word(6, 32'h6666_0006);
    load_word(7, 32'h7777_0007);
    ce[0] = 1'b1; addr[0] = 32'h18;
    settle(); tick();
    rst = 1'b1;
    addr[0] = 32'h1C;
    settle(); tick();
    rst = 1'b0;
    settle();
    checks++; if (inst_valid[0] !== 1'b0) begin errors++; $display("FAIL rst_abort_valid: got %b want 0", inst_valid[0]); end
    checks++; if (inst[0] !== 32'h0) begin errors++; $display("FAIL rst_abort_inst: got %h want 0", inst[0]); end
    fetch_one(0, 32'h1C, gi, gm, lat);
    checks++; if (lat != 3 || gi !== 32'h7777_0007) begin errors++; $display("FAIL rst_abort_next: got inst %h lat %0d want 77770007/3", gi, lat); end
    ce[0] = 1'b0;
    tick();
  endtask

  task automatic test_rbw_and_wrap();
    logic [31:0] gi;
    logic        gm;
    int          lat;
    load_word(5, 32'h1234_5678);
    ce[0] = 1'b1; addr[0] = 32'h14;
    settle(); tick();
    settle(); tick();
    load_we = 1'b1; load_addr = DL2'(5); load_data = 32'hDEAD_BEEF;
    settle(); tick();
    load_we = 1'b0;
    mem_model[5] = 32'hDEAD_BEEF;
    settle();
    checks++; if (inst_valid[0] !== 1'b1 || inst[0] !== 32'h1234_5678) begin errors++; $display("FAIL rbw_old: got valid %b inst %h want 1/12345678", inst_valid[0], inst[0]); end
    fetch_one(0, 32'h14, gi, gm, lat);
    checks++; if (lat != 3 || gi !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rbw_refetch: got inst %h lat %0d want deadbeef/3", gi, lat); end
    ce[0] = 1'b0;
    tick();
    load_word(0, 32'hCAFE_0000);
    fetch_one(0, 32'h0000_1000, gi, gm, lat);
    checks++; if (gi !== 32'hCAFE_0000 || gm !== 1'b0) begin errors++; $display("FAIL wrap_w2: got inst %h mis %b want cafe0000/0", gi, gm); end
    ce[0] = 1'b0;
    tick();
    fetch_one(1, 32'hFFFF_F004, gi, gm, lat);
    checks++; if (gi !== mem_model[1]) begin errors++; $display("FAIL wrap_w0: got inst %h want %h", gi, mem_model[1]); end
    ce[1] = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [3:0]  ri;
    logic [1:0]  lo;
    bit          exp_stall;
    bit          resp;
    ce = '0;
    for (int k = 0; k < 16; k++) load_word(k, $urandom());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int g = 0; g < N; g++) begin
      m_busy[g] = 1'b0; m_vld[g] = 1'b0; m_inst[g] = '0; m_misq[g] = 1'b0;
    end
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int g = 0; g < N; g++) begin
        r  = $urandom();
        ri = 4'($urandom_range(0, 15));
        lo = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        ce[g]   = ($urandom_range(0, 7) != 0);
        addr[g] = {r[31:12], 6'd0, ri, lo};
      end
      load_we   = ($urandom_range(0, 3) == 0);
      load_addr = DL2'($urandom_range(0, 15));
      load_data = $urandom();
      settle();
      for (int g = 0; g < N; g++) begin
        exp_stall = ce[g] && (m_busy[g] ? (m_age[g] < wc[g]) : (wc[g] > 0));
        checks++; if (stallreq[g] !== exp_stall) begin errors++; $display("FAIL rnd_stall[%0d] c%0d: got %b want %b", g, c, stallreq[g], exp_stall); end
        checks++; if (inst_valid[g] !== m_vld[g]) begin errors++; $display("FAIL rnd_valid[%0d] c%0d: got %b want %b", g, c, inst_valid[g], m_vld[g]); end
        checks++; if (inst[g] !== m_inst[g]) begin errors++; $display("FAIL rnd_inst[%0d] c%0d: got %h want %h", g, c, inst[g], m_inst[g]); end
        if (m_vld[g]) begin
          checks++; if (misaligned[g] !== m_misq[g]) begin errors++; $display("FAIL rnd_mis[%0d] c%0d: got %b want %b", g, c, misaligned[g], m_misq[g]); end
        end
      end
      // Advance the model across the coming edge (memory read before write).
      for (int g = 0; g < N; g++) begin
        if (rst) begin
          m_busy[g] = 1'b0; m_vld[g] = 1'b0; m_inst[g] = '0; m_misq[g] = 1'b0;
        end else begin
          resp = 1'b0;
          if (m_busy[g]) begin
            if (!ce[g]) m_busy[g] = 1'b0;
            else if (m_age[g] == wc[g]) begin resp = 1'b1; m_busy[g] = 1'b0; end
            else m_age[g]++;
          end else if (ce[g]) begin
            m_idx[g] = int'(addr[g][DL2+1:2]);
            m_mis[g] = (addr[g][1:0] != 2'b00);
            if (wc[g] == 0) resp = 1'b1;
            else begin m_busy[g] = 1'b1; m_age[g] = 1; end
          end
          m_vld[g] = resp;
          if (resp) begin
            m_inst[g] = m_mis[g] ? 32'h0 : mem_model[m_idx[g]];
            m_misq[g] = m_mis[g];
          end
        end
      end
      if (load_we) mem_model[int'(load_addr)] = load_data;
      tick();
    end
    rst = 1'b0;
    ce = '0;
    load_we = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    ce        = '0;
    addr      = '0;
    load_we   = 1'b0;
    load_addr = '0;
    load_data = '0;
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_pc_stream();
    test_misaligned();
    test_abort_ce();
    test_abort_rst();
    test_rbw_and_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
